// File: rtl/pc_redirect_unit_if.sv
// Bundle of EX-stage inputs and fetch/redirect outputs for pc_redirect_unit.
// Defining BRANCH_STATS_EN adds the stat_taken / stat_not_taken counters.
interface pc_redirect_unit_if;
  logic        stall_in;
  logic        ex_valid;
  logic        ex_is_branch;
  logic        ex_is_jal;
  logic        ex_is_jalr;
  logic        branch_taken_in;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] ex_rs1;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4_out;
  logic [31:0] ex_link_out;
  logic        redirect_out;
  logic        flush_out;
  logic        misalign_exc_out;
  logic [31:0] exc_addr_out;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_taken;
  logic [31:0] stat_not_taken;

  modport slave (
    input  stall_in, ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr,
           branch_taken_in, ex_pc, ex_imm, ex_rs1,
    output pc_out, pc_plus4_out, ex_link_out, redirect_out, flush_out,
           misalign_exc_out, exc_addr_out, stat_taken, stat_not_taken
  );

  modport master (
    output stall_in, ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr,
           branch_taken_in, ex_pc, ex_imm, ex_rs1,
    input  pc_out, pc_plus4_out, ex_link_out, redirect_out, flush_out,
           misalign_exc_out, exc_addr_out, stat_taken, stat_not_taken
  );
`else
  modport slave (
    input  stall_in, ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr,
           branch_taken_in, ex_pc, ex_imm, ex_rs1,
    output pc_out, pc_plus4_out, ex_link_out, redirect_out, flush_out,
           misalign_exc_out, exc_addr_out
  );

  modport master (
    output stall_in, ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr,
           branch_taken_in, ex_pc, ex_imm, ex_rs1,
    input  pc_out, pc_plus4_out, ex_link_out, redirect_out, flush_out,
           misalign_exc_out, exc_addr_out
  );
`endif
endinterface

// File: rtl/pc_redirect_unit.sv
// Fetch PC owner: resolves EX-stage branch/JAL/JALR, redirects fetch, flushes IF/ID, traps misaligned targets.
// Optional feature macro BRANCH_STATS_EN adds saturating taken/not-taken branch counters.
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic               clk,
  input logic               rst,
  pc_redirect_unit_if.slave bus
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Counter value that makes FLUSH last FLUSH_CYCLES-1 cycles after the redirect cycle.
  localparam logic [3:0] CNT_INIT = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;

  state_t      r_state;
  state_t      w_stateNext;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cntNext;
  logic [31:0] r_pc;
  logic [31:0] w_pcNext;
  logic [31:0] r_excAddr;
  logic [31:0] w_target;
  logic        w_accept;
  logic        w_take;
  logic        w_mis;

  always_comb begin
    w_target = bus.ex_pc + bus.ex_imm;
    if (bus.ex_is_jalr) begin
      w_target = (bus.ex_rs1 + bus.ex_imm) & ~32'h1;
    end
  end

  assign w_accept = bus.ex_valid & ~bus.stall_in & (r_state == RUN);
  assign w_take   = w_accept & (bus.ex_is_jalr | bus.ex_is_jal |
                                (bus.ex_is_branch & bus.branch_taken_in));
  assign w_mis    = w_take & (w_target[1:0] != 2'b00);

  assign bus.pc_out           = r_pc;
  assign bus.exc_addr_out     = r_excAddr;
  assign bus.pc_plus4_out     = rst ? 32'h0 : r_pc + 32'd4;
  assign bus.ex_link_out      = rst ? 32'h0 : bus.ex_pc + 32'd4;
  assign bus.redirect_out     = ~rst & w_take;
  assign bus.misalign_exc_out = ~rst & w_mis;
  assign bus.flush_out        = ~rst & (w_take | (r_state == FLUSH));

  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    case (r_state)
      RUN: begin
        if (w_take && (FLUSH_CYCLES > 1)) begin
          w_stateNext = FLUSH;
          w_cntNext   = CNT_INIT;
        end
      end
      FLUSH: begin
        if (!bus.stall_in) begin
          if (r_cnt == 4'd0) begin
            w_stateNext = RUN;
          end else begin
            w_cntNext = r_cnt - 4'd1;
          end
        end
      end
      default: w_stateNext = RUN;
    endcase
  end

  // Trap outranks the redirect; fetch keeps advancing through the flush window.
  always_comb begin
    w_pcNext = r_pc + 32'd4;
    if (w_mis) begin
      w_pcNext = TRAP_VECTOR;
    end else if (w_take) begin
      w_pcNext = w_target;
    end else if (bus.stall_in) begin
      w_pcNext = r_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= RUN;
      r_cnt     <= 4'd0;
      r_pc      <= RESET_PC;
      r_excAddr <= 32'h0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
      r_pc    <= w_pcNext;
      if (w_mis) begin
        r_excAddr <= w_target;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  logic        w_branchOnly;
  logic [31:0] r_statTaken;
  logic [31:0] r_statNotTaken;

  assign w_branchOnly       = w_accept & bus.ex_is_branch & ~bus.ex_is_jal & ~bus.ex_is_jalr;
  assign bus.stat_taken     = r_statTaken;
  assign bus.stat_not_taken = r_statNotTaken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_statTaken    <= 32'h0;
      r_statNotTaken <= 32'h0;
    end else begin
      if (w_branchOnly && bus.branch_taken_in && (r_statTaken != 32'hFFFF_FFFF)) begin
        r_statTaken <= r_statTaken + 32'd1;
      end
      if (w_branchOnly && !bus.branch_taken_in && (r_statNotTaken != 32'hFFFF_FFFF)) begin
        r_statNotTaken <= r_statNotTaken + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Owns the architectural fetch PC and consumes the EX-stage branch decision (`branch_taken_in`) produced by the branch comparator.
- Computes branch/JAL/JALR targets, redirects fetch and flushes younger IF/ID instructions for a fixed window.
- Traps misaligned control-flow targets to a fixed vector.
- Sits between EX-stage resolution and the instruction-fetch stage.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
TRAP_VECTOR, 32'h0000_0100, redirect target on misaligned control-flow target.
FLUSH_CYCLES, 2, total cycles `flush_out` is high per redirect (legal range 1..15).

Ports:
clk  in  1  core clock, rising edge.
rst  in  1  asynchronous, active-high reset.
stall_in  in  1  pipeline freeze; PC, state and counter hold.
ex_valid  in  1  EX holds a valid control-flow instruction.
ex_is_branch  in  1  conditional branch in EX.
ex_is_jal  in  1  JAL in EX.
ex_is_jalr  in  1  JALR in EX.
branch_taken_in  in  1  comparator decision for ex_is_branch.
ex_pc  in  32  PC of the EX instruction.
ex_imm  in  32  sign-extended immediate.
ex_rs1  in  32  rs1 value (JALR base).
pc_out  out  32  current fetch PC (registered).
pc_plus4_out  out  32  pc_out+4, combinational.
ex_link_out  out  32  ex_pc+4, link value for JAL/JALR.
redirect_out  out  1  combinational: a redirect is taken this cycle.
flush_out  out  1  kill IF/ID contents.
misalign_exc_out  out  1  one-cycle pulse (combinational) on trapped target.
exc_addr_out  out  32  registered offending target; holds until next trap.

Behaviour:
- Reset (async, any time, including mid-flush): `pc_out`=RESET_PC, state=RUN, cnt=0, `exc_addr_out`=0, stats counters=0.
- While rst is high, combinational outputs are forced 0.
- `accept` = ex_valid & ~stall_in & (state==RUN). Any EX instruction is ignored in FLUSH state or while stalled.
- `take` = accept & (ex_is_jalr | ex_is_jal | (ex_is_branch & branch_taken_in)).
- Decode priority when several flags are set: jalr > jal > branch.
- Target computation (mod 2^32, wrap silently):
  - branch/jal target = ex_pc + ex_imm.
  - jalr target = (ex_rs1 + ex_imm) & ~32'h1.
- Misalignment: `mis` = take & (target[1:0] != 0). The check applies only to taken transfers; a not-taken branch with a bad target never traps.
- Per-cycle outputs:
  - `redirect_out` = take.
  - `misalign_exc_out` = mis.
  - `flush_out` = take | (state==FLUSH).
- Next PC, in priority order:
  1. mis → TRAP_VECTOR, and `exc_addr_out` <= target.
  2. take → target.
  3. stall_in → hold.
  4. otherwise → pc_out + 4.
- State machine (RUN, FLUSH):
  - RUN → FLUSH on take when FLUSH_CYCLES>1; cnt <= FLUSH_CYCLES-2.
  - FLUSH: if ~stall_in, then if cnt==0 → RUN, else cnt--. If stall_in, hold.
  - With FLUSH_CYCLES==1 the FSM never leaves RUN.
- Result: `flush_out` is high for exactly FLUSH_CYCLES unstalled cycles per redirect, counting the redirect cycle itself.
- PC keeps incrementing during FLUSH; those fetches are the ones being flushed on later cycles.
- Stall on the redirect cycle: take is suppressed, and EX re-presents the instruction when the stall drops. There is no double redirect.
- PC wrap: 32'hFFFF_FFFC + 4 → 32'h0000_0000.

Optional Feature:
BRANCH_STATS_EN
- Defined: adds outputs `stat_taken` [31:0] and `stat_not_taken` [31:0].
  - `stat_taken` increments when accept & ex_is_branch & branch_taken_in & ~ex_is_jal & ~ex_is_jalr.
  - `stat_not_taken` increments on the same condition with branch_taken_in low.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset → pc_out=0; 3 unstalled cycles → 4, 8, 12; flush_out=0 throughout.
- At pc 0x20, BEQ ex_pc=0x10, imm=0x40, taken=1 → redirect_out=1, flush_out=1 that cycle and the next (FLUSH_CYCLES=2), then pc_out=0x50, 0x54. Not-taken variant → no flush, PC continues to 0x24.
- JALR ex_rs1=0x1001, imm=0x2 → target 0x1002 → misalign_exc_out pulses once, pc_out=0x100, exc_addr_out=0x1002.
- JAL taken with stall_in=1 for 2 cycles → PC holds and no redirect. Stall drops → single redirect; flush window begins. A second ex_valid during FLUSH is ignored.
- rst asserted in the middle of the flush window → pc_out=RESET_PC immediately, flush_out=0 next cycle, FSM in RUN.
- With BRANCH_STATS_EN: 3 taken + 2 not-taken branches (flush gaps respected) → stat_taken=3, stat_not_taken=2. Counter preloaded to 0xFFFF_FFFF plus one taken branch → stays 0xFFFF_FFFF.
